rr_sel_sequencer: RTL and testbench

Round-robin select sequencer that drives the 2-bit select of the 4:1 data multiplexer in the combinational datapath. It arbitrates among four channel requests and grants one channel at a time for a fixed slot of HOLD_CYCLES clocks. It presents the winner as a registered binary select plus a one-hot grant, so the downstream mux output is valid only while valid_out is high.

---
 rtl/rr_sel_sequencer.sv | 113 +++++++++++
 tb/tb_rr_sel_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_sel_sequencer.sv
// Round-robin select sequencer: grants one of four channel requests for a
// fixed slot of HOLD_CYCLES clocks and drives the 2-bit select of a 4:1 mux.
module rr_sel_sequencer #(
    parameter int unsigned HOLD_CYCLES = 4   // legal range 1..255
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       en_in,
    input  logic [3:0] req_in,
    output logic [1:0] sel_out,
    output logic [3:0] grant_out,
    output logic       valid_out,
    output logic       slot_done_out
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    localparam logic [7:0] LP_RELOAD = 8'(HOLD_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_sel;
    logic [3:0] r_grant;
    logic       r_valid;
    logic [7:0] r_cnt;
    logic [1:0] r_last;

    logic [1:0] w_winner;
    logic       w_any_req;

    assign w_any_req = |req_in;

    // Scan starts just after the last-served channel, so it has lowest priority.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        // NOTE: every variable gets a default first so no latch is inferred.
        w_winner = r_last;
        found    = 1'b0;
        idx      = r_last;
        for (int k = 1; k <= 4; k++) begin
            idx = r_last + 2'(k);
            if (!found && req_in[idx]) begin
                w_winner = idx;
                found    = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
            r_sel   <= 2'b00;
            r_grant <= 4'b0000;
            r_valid <= 1'b0;
            r_cnt   <= 8'd0;
            r_last  <= 2'b11;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en_in && w_any_req) begin
                        r_state <= S_GRANT;
                        r_sel   <= w_winner;
                        r_grant <= 4'b0001 << w_winner;
                        r_valid <= 1'b1;
                        r_cnt   <= LP_RELOAD;
                        r_last  <= w_winner;
                    end else begin
                        r_grant <= 4'b0000;
                        r_valid <= 1'b0;
                        r_cnt   <= 8'd0;
                    end
                end
                S_GRANT: begin
                    if (!en_in) begin
                        r_state <= S_IDLE;
                        r_grant <= 4'b0000;
                        r_valid <= 1'b0;
                        r_cnt   <= 8'd0;
                    end else if (req_in[r_sel] && (r_cnt != 8'd0)) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (w_any_req) begin
                        // Back-to-back slot; sel_out may stay put on a sole requester.
                        r_sel   <= w_winner;
                        r_grant <= 4'b0001 << w_winner;
                        r_cnt   <= LP_RELOAD;
                        r_last  <= w_winner;
                    end else begin
                        r_state <= S_IDLE;
                        r_grant <= 4'b0000;
                        r_valid <= 1'b0;
                        r_cnt   <= 8'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 4'b0000;
                    r_valid <= 1'b0;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    assign sel_out       = r_sel;
    assign grant_out     = r_grant;
    assign valid_out     = r_valid;
    assign slot_done_out = r_valid & (r_cnt == 8'd0);

endmodule

// File: tb/tb_rr_sel_sequencer.sv
// Scoreboard bench for rr_sel_sequencer: two instances (HOLD_CYCLES 4 and 1)
// share stimulus and are checked against a slot-level reference model.
module tb_rr_sel_sequencer;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] grant;
        logic       valid;
        logic       done;
    } out_t;

    logic       clk_in   = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       en_in    = 1'b0;
    logic [3:0] req_in   = 4'b0000;

    logic [1:0] sel_a, sel_b;
    logic [3:0] grant_a, grant_b;
    logic       valid_a, valid_b, done_a, done_b;

    rr_sel_sequencer #(.HOLD_CYCLES(4)) u_dut_h4 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .en_in(en_in), .req_in(req_in),
        .sel_out(sel_a), .grant_out(grant_a), .valid_out(valid_a), .slot_done_out(done_a)
    );

    rr_sel_sequencer #(.HOLD_CYCLES(1)) u_dut_h1 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .en_in(en_in), .req_in(req_in),
        .sel_out(sel_b), .grant_out(grant_b), .valid_out(valid_b), .slot_done_out(done_b)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    out_t exp_q[2][$];

    // Reference model: a slot is "active" with some number of cycles remaining.
    int   hold_len[2] = '{4, 1};
    bit   m_active[2];
    int   m_sel[2];
    int   m_last[2];
    int   m_rem[2];

    function automatic int pick(input logic [3:0] req, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (req[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_sel[i]    = 0;
            m_last[i]   = 3;
            m_rem[i]    = 0;
        end
    endfunction

    function automatic void start_slot(input int i, input logic [3:0] req);
        m_sel[i]    = pick(req, m_last[i]);
        m_last[i]   = m_sel[i];
        m_rem[i]    = hold_len[i];
        m_active[i] = 1'b1;
    endfunction

    function automatic void model_step(input int i, input logic en, input logic [3:0] req);
        if (!m_active[i]) begin
            if (en && req != 4'b0) start_slot(i, req);
        end else if (!en) begin
            m_active[i] = 1'b0;
        end else if (req[m_sel[i]] && m_rem[i] > 1) begin
            m_rem[i]--;
        end else if (req != 4'b0) begin
            start_slot(i, req);
        end else begin
            m_active[i] = 1'b0;
        end
    endfunction

    function automatic out_t model_out(input int i);
        out_t o;
        o.sel   = 2'(m_sel[i]);
        o.grant = m_active[i] ? (4'b0001 << m_sel[i]) : 4'b0000;
        o.valid = m_active[i];
        o.done  = m_active[i] && (m_rem[i] == 1);
        return o;
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got sel=%0d grant=%b valid=%b done=%b, expected sel=%0d grant=%b valid=%b done=%b",
                     name, $time, got.sel, got.grant, got.valid, got.done,
                     exp.sel, exp.grant, exp.valid, exp.done);
        end
    endtask

    function automatic out_t dut_out(input int i);
        out_t o;
        if (i == 0) o = '{sel: sel_a, grant: grant_a, valid: valid_a, done: done_a};
        else        o = '{sel: sel_b, grant: grant_b, valid: valid_b, done: done_b};
        return o;
    endfunction

    // One clock of stimulus: drive at the falling edge, predict the next rising edge.
    task automatic cycle(input logic en, input logic [3:0] req, input logic rst_n);
        logic was_running;
        @(negedge clk_in);
        en_in  = en;
        req_in = req;
        if (!rst_n) begin
            was_running = rst_n_in;
            rst_n_in    = 1'b0;
            model_reset();
            if (was_running) begin
                #1;
                check("async_reset_h4", dut_out(0), out_t'(0));
                check("async_reset_h1", dut_out(1), out_t'(0));
            end
        end else begin
            rst_n_in = 1'b1;
            for (int i = 0; i < 2; i++) model_step(i, en, req);
        end
        for (int i = 0; i < 2; i++) exp_q[i].push_back(model_out(i));
    endtask

    // Monitor: compares every rising edge for which a prediction exists.
    initial begin
        out_t e;
        forever begin
            @(posedge clk_in);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (exp_q[i].size() > 0) begin
                    e = exp_q[i].pop_front();
                    check(i == 0 ? "slot_h4" : "slot_h1", dut_out(i), e);
                end
            end
        end
    end

    initial begin
        logic [3:0] r;
        int         len;
        model_reset();

        // Reset state
        repeat (2) cycle(1'b0, 4'b0000, 1'b0);

        // Full rotation with all requesting, then reset mid-slot
        repeat (18) cycle(1'b1, 4'b1111, 1'b1);
        cycle(1'b1, 4'b1111, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);

        // Fairness between channels 1 and 3
        repeat (20) cycle(1'b1, 4'b1010, 1'b1);
        repeat (2)  cycle(1'b1, 4'b0000, 1'b1);

        // Early release of channel 2 while channel 0 waits
        repeat (2) cycle(1'b1, 4'b0100, 1'b1);
        cycle(1'b1, 4'b0101, 1'b1);
        repeat (5) cycle(1'b1, 4'b0001, 1'b1);

        // Sole requester on channel 3
        repeat (12) cycle(1'b1, 4'b1000, 1'b1);
        cycle(1'b1, 4'b0000, 1'b1);

        // Enable drop during a slot on channel 1, then re-enable
        repeat (2) cycle(1'b1, 4'b0010, 1'b1);
        repeat (2) cycle(1'b0, 4'b0010, 1'b1);
        repeat (6) cycle(1'b1, 4'b0011, 1'b1);

        // Alternating pair, then requests vanish
        repeat (8) cycle(1'b1, 4'b0101, 1'b1);
        repeat (3) cycle(1'b1, 4'b0000, 1'b1);

        // Randomised traffic with occasional enable drops and resets
        repeat (120) begin
            r   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) begin
                cycle(($urandom_range(0, 15) != 0), r, ($urandom_range(0, 99) != 0));
            end
        end

        repeat (3) @(posedge clk_in);
        #2;
        n_vec++;
        if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d/%0d predictions left, expected 0/0",
                     exp_q[0].size(), exp_q[1].size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
